sram_row_reader: RTL and testbench

Read-side controller for the 64-entry × 512-bit weight/activation SRAM (active-low `csb`/`wsb`, one-cycle registered read). On a start command it fetches a contiguous run of rows (with address wrap-around), absorbs the SRAM read latency in a small FIFO, and presents each 512-bit row to the systolic-array feeder over a valid/ready stream. It sits between the SRAM macro and the array input staging logic, and is the consumer of rows that the weight loader writes.

---
 rtl/sram_row_reader_if.sv | 57 +++++
 rtl/sram_row_reader.sv | 177 +++++++++++++++++
 tb/tb_sram_row_reader.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_row_reader_if.sv
// -----------------------------------------------------------------------------
// sram_row_reader_if
// Bundles the two buses of the SRAM row reader: the read port of the
// 64 x 512-bit SRAM macro and the valid/ready row stream toward the
// systolic-array feeder.
//
// Signals:
//   sram_csb    chip enable, active low (reader drives)
//   sram_wsb    write enable, active low (reader drives, always 1)
//   sram_raddr  read address (reader drives)
//   sram_rdata  read data, valid the cycle after csb low (macro drives)
//   out_valid   stream holds a row (reader drives)
//   out_ready   consumer accepts (feeder drives)
//   out_data    row data (reader drives)
//   out_last    final row of the command (reader drives)
//
// Modports:
//   master  the row reader itself
//   slave   the environment (SRAM macro + feeder)
// -----------------------------------------------------------------------------
interface sram_row_reader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 512
);

  logic              sram_csb;
  logic              sram_wsb;
  logic [ADDR_W-1:0] sram_raddr;
  logic [DATA_W-1:0] sram_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output sram_csb,
    output sram_wsb,
    output sram_raddr,
    input  sram_rdata,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  sram_csb,
    input  sram_wsb,
    input  sram_raddr,
    output sram_rdata,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/sram_row_reader.sv
// -----------------------------------------------------------------------------
// sram_row_reader
// Read-side controller for the weight/activation SRAM. A start command fetches
// a contiguous run of rows (address wraps modulo 2^ADDR_W), soaks up the
// one-cycle SRAM read latency in a small FIFO and streams each row out over a
// valid/ready handshake, flagging the final row with out_last.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      command strobe, only looked at while idle
//   base_addr_i  first row address, latched on an accepted start
//   row_cnt_i    number of rows 0..2^ADDR_W, latched on an accepted start
//   busy_o       command in progress
//   done_o       one-cycle completion pulse
//   bus          SRAM read port + output row stream (master side)
// -----------------------------------------------------------------------------
module sram_row_reader #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 512,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   row_cnt_i,
  output logic              busy_o,
  output logic              done_o,
  sram_row_reader_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   issuePtr_q, issuePtr_d;
  logic [ADDR_W:0]     remain_q, remain_d;
  logic                inflight_q, inflight_d;
  logic                inflightLast_q, inflightLast_d;
  logic                done_q, done_d;
  logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic                lastMem_q [FIFO_DEPTH];

  logic                issue;
  logic                lastIssue;
  logic                push;
  logic                pop;
  logic                fifoValid;
  logic                headLast;
  logic [CNT_W:0]      creditUsed;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit check: a slot is reserved for every row already buffered plus the
  // read whose data comes back next cycle. A pop in this cycle is not counted
  // as free space, which keeps the check off the out_ready path.
  always_comb begin
    creditUsed = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    issue      = (state_q == ISSUE) && (creditUsed < (CNT_W + 1)'(FIFO_DEPTH));
    lastIssue  = (remain_q == (ADDR_W + 1)'(1));
    push       = inflight_q;
    fifoValid  = (count_q != '0);
    pop        = fifoValid && bus.out_ready;
    headLast   = lastMem_q[rdPtr_q];
  end

  // Next-state logic for the command FSM, the issue pointer/counter and the
  // one-deep in-flight tracker that tags the returning row with its last flag.
  always_comb begin
    state_d        = state_q;
    issuePtr_d     = issuePtr_q;
    remain_d       = remain_q;
    inflight_d     = issue;
    inflightLast_d = issue && lastIssue;
    done_d         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (row_cnt_i != '0) begin
            issuePtr_d = base_addr_i;
            remain_d   = row_cnt_i;
            state_d    = ISSUE;
          end else begin
            // Empty command completes immediately without going busy.
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          issuePtr_d = issuePtr_q + ADDR_W'(1);
          remain_d   = remain_q - (ADDR_W + 1)'(1);
          if (lastIssue) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && headLast) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO pointer and occupancy bookkeeping; push and pop may coincide.
  always_comb begin
    wrPtr_d = push ? ptrInc(wrPtr_q) : wrPtr_q;
    rdPtr_d = pop  ? ptrInc(rdPtr_q) : rdPtr_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Control state. Clearing inflight_q on reset is what throws away a read
  // that was issued just before reset and returns just after it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      issuePtr_q     <= '0;
      remain_q       <= '0;
      inflight_q     <= 1'b0;
      inflightLast_q <= 1'b0;
      done_q         <= 1'b0;
      wrPtr_q        <= '0;
      rdPtr_q        <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      issuePtr_q     <= issuePtr_d;
      remain_q       <= remain_d;
      inflight_q     <= inflight_d;
      inflightLast_q <= inflightLast_d;
      done_q         <= done_d;
      wrPtr_q        <= wrPtr_d;
      rdPtr_q        <= rdPtr_d;
      count_q        <= count_d;
    end
  end

  // FIFO storage is not reset; its contents are only visible while the
  // occupancy count says they are valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wrPtr_q]     <= bus.sram_rdata;
      lastMem_q[wrPtr_q] <= inflightLast_q;
    end
  end

  assign bus.sram_csb   = ~issue;
  assign bus.sram_wsb   = 1'b1;
  assign bus.sram_raddr = issuePtr_q;

  // Data and last are forced to zero while empty so stale entries never leak.
  assign bus.out_valid  = fifoValid;
  assign bus.out_data   = fifoValid ? mem_q[rdPtr_q] : '0;
  assign bus.out_last   = fifoValid && headLast;

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_sram_row_reader.sv
// -----------------------------------------------------------------------------
// tb_sram_row_reader
// Directed self-checking bench for sram_row_reader: reset values, streaming
// with wrap-around, empty and full-depth commands, backpressure, start while
// busy and reset in the middle of a command. A small SRAM model with a
// one-cycle registered read supplies row data.
// -----------------------------------------------------------------------------
module tb_sram_row_reader;

  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 512;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] baseAddr = '0;
  logic [ADDR_W:0]   rowCnt = '0;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] sramMem [64];

  sram_row_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_row_reader #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .base_addr_i(baseAddr),
    .row_cnt_i  (rowCnt),
    .busy_o     (busy),
    .done_o     (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // SRAM macro model: registered read, data appears the cycle after csb low.
  always @(posedge clk) begin
    if (bus.sram_csb === 1'b0) begin
      bus.sram_rdata <= sramMem[bus.sram_raddr];
    end
  end

  // Distinct content per row: row index, word index and a row-dependent tag.
  function automatic logic [DATA_W-1:0] rowPat(input int r);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) begin
      v[k*32 +: 32] = {8'(r), 8'(k), 16'hBEEF ^ 16'(r * 257)};
    end
    return v;
  endfunction

  // One-cycle start pulse; returns at the first negedge after the sampling edge.
  task automatic applyStimulus(input int b, input int c);
    @(negedge clk);
    start    = 1'b1;
    baseAddr = ADDR_W'(b);
    rowCnt   = (ADDR_W + 1)'(c);
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (bus.sram_csb !== 1'b1) begin errors++; $display("[TB] FAIL reset_csb: got %b expected 1", bus.sram_csb); end
    checks++; if (bus.sram_wsb !== 1'b1) begin errors++; $display("[TB] FAIL reset_wsb: got %b expected 1", bus.sram_wsb); end
    checks++; if (bus.sram_raddr !== 6'd0) begin errors++; $display("[TB] FAIL reset_raddr: got %0d expected 0", bus.sram_raddr); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %b expected 0", bus.out_last); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", bus.out_data); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Cycle-exact streaming with out_ready held high. k counts negedges after
  // the start edge: issue in k=1..cnt, row i valid at k=3+i, done at cnt+3.
  task automatic test_stream(input string name, input int base, input int cnt);
    logic expValid;
    logic expIssue;
    bus.out_ready = 1'b1;
    applyStimulus(base, cnt);
    for (int k = 1; k <= cnt + 4; k++) begin
      expValid = (k >= 3) && (k <= cnt + 2);
      expIssue = (k <= cnt);
      checks++;
      if (bus.out_valid !== expValid) begin
        errors++; $display("[TB] FAIL %s_valid k=%0d: got %b expected %b", name, k, bus.out_valid, expValid);
      end
      if (expValid) begin
        checks++;
        if (bus.out_data !== rowPat((base + k - 3) % 64)) begin
          errors++; $display("[TB] FAIL %s_data k=%0d: got %h expected %h", name, k, bus.out_data, rowPat((base + k - 3) % 64));
        end
        checks++;
        if (bus.out_last !== logic'(k == cnt + 2)) begin
          errors++; $display("[TB] FAIL %s_last k=%0d: got %b expected %b", name, k, bus.out_last, (k == cnt + 2));
        end
      end
      checks++;
      if (busy !== logic'(k <= cnt + 2)) begin
        errors++; $display("[TB] FAIL %s_busy k=%0d: got %b expected %b", name, k, busy, (k <= cnt + 2));
      end
      checks++;
      if (done !== logic'(k == cnt + 3)) begin
        errors++; $display("[TB] FAIL %s_done k=%0d: got %b expected %b", name, k, done, (k == cnt + 3));
      end
      checks++;
      if (bus.sram_csb !== ~expIssue) begin
        errors++; $display("[TB] FAIL %s_csb k=%0d: got %b expected %b", name, k, bus.sram_csb, ~expIssue);
      end
      if (expIssue) begin
        checks++;
        if (bus.sram_raddr !== ADDR_W'((base + k - 1) % 64) || bus.sram_wsb !== 1'b1) begin
          errors++; $display("[TB] FAIL %s_raddr k=%0d: got %0d/wsb %b expected %0d/wsb 1", name, k, bus.sram_raddr, bus.sram_wsb, (base + k - 1) % 64);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_zero_count();
    bus.out_ready = 1'b1;
    applyStimulus(7, 0);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done: got %b expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy: got %b expected 0", busy); end
    checks++; if (bus.sram_csb !== 1'b1) begin errors++; $display("[TB] FAIL zero_csb: got %b expected 1", bus.sram_csb); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL zero_done_pulse: got %b expected 0", done); end
    checks++; if (bus.sram_csb !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_idle: got csb %b busy %b expected csb 1 busy 0", bus.sram_csb, busy); end
  endtask

  task automatic test_backpressure();
    logic [15:0]       readyPat;
    logic              prevStall;
    logic [DATA_W-1:0] prevData;
    logic              seenDone;
    int                issues;
    int                idx;
    readyPat  = 16'b1011_0010_1110_0101;
    bus.out_ready = 1'b0;
    issues    = 0;
    applyStimulus(60, 8);
    for (int k = 1; k <= 10; k++) begin
      if (bus.sram_csb === 1'b0) issues++;
      if (k >= 3) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== rowPat(60)) begin
          errors++; $display("[TB] FAIL bp_stall_head k=%0d: got valid %b data %h expected valid 1 data %h", k, bus.out_valid, bus.out_data, rowPat(60));
        end
      end
      @(negedge clk);
    end
    checks++;
    if (issues != FIFO_DEPTH) begin
      errors++; $display("[TB] FAIL bp_issue_count: got %0d expected %0d", issues, FIFO_DEPTH);
    end
    idx = 0; prevStall = 1'b0; prevData = '0; seenDone = 1'b0;
    for (int cyc = 0; cyc < 200 && !seenDone; cyc++) begin
      bus.out_ready = readyPat[cyc % 16];
      if (prevStall) begin
        checks++;
        if (bus.out_data !== prevData) begin
          errors++; $display("[TB] FAIL bp_stable cyc=%0d: got %h expected %h", cyc, bus.out_data, prevData);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.out_data !== rowPat((60 + idx) % 64)) begin
          errors++; $display("[TB] FAIL bp_data idx=%0d: got %h expected %h", idx, bus.out_data, rowPat((60 + idx) % 64));
        end
        checks++;
        if (bus.out_last !== logic'(idx == 7)) begin
          errors++; $display("[TB] FAIL bp_last idx=%0d: got %b expected %b", idx, bus.out_last, (idx == 7));
        end
        idx++;
      end
      if (done === 1'b1) seenDone = 1'b1;
      prevStall = bus.out_valid && !bus.out_ready;
      prevData  = bus.out_data;
      @(negedge clk);
    end
    checks++; if (idx != 8) begin errors++; $display("[TB] FAIL bp_row_count: got %0d expected 8", idx); end
    checks++; if (!seenDone) begin errors++; $display("[TB] FAIL bp_done: got no done expected done pulse"); end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_back_to_back_start();
    logic seenDone;
    int   idx;
    int   issueIdx;
    int   lateIssues;
    bus.out_ready = 1'b1;
    applyStimulus(20, 6);
    issueIdx = 0;
    checks++;
    if (bus.sram_csb !== 1'b0 || bus.sram_raddr !== 6'd20) begin
      errors++; $display("[TB] FAIL busy_first_issue: got csb %b addr %0d expected csb 0 addr 20", bus.sram_csb, bus.sram_raddr);
    end
    issueIdx = 1;
    start = 1'b1; baseAddr = 6'd40; rowCnt = 7'd3;
    @(negedge clk);
    start = 1'b0;
    idx = 0; seenDone = 1'b0;
    for (int k = 0; k < 40 && !seenDone; k++) begin
      if (bus.sram_csb === 1'b0) begin
        checks++;
        if (bus.sram_raddr !== ADDR_W'(20 + issueIdx)) begin
          errors++; $display("[TB] FAIL busy_raddr n=%0d: got %0d expected %0d", issueIdx, bus.sram_raddr, 20 + issueIdx);
        end
        issueIdx++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.out_data !== rowPat(20 + idx) || bus.out_last !== logic'(idx == 5)) begin
          errors++; $display("[TB] FAIL busy_row idx=%0d: got last %b data %h expected last %b data %h", idx, bus.out_last, bus.out_data, (idx == 5), rowPat(20 + idx));
        end
        idx++;
      end
      if (done === 1'b1) seenDone = 1'b1;
      @(negedge clk);
    end
    checks++; if (idx != 6 || issueIdx != 6) begin errors++; $display("[TB] FAIL busy_counts: got rows %0d issues %0d expected 6 and 6", idx, issueIdx); end
    checks++; if (!seenDone) begin errors++; $display("[TB] FAIL busy_done: got no done expected done pulse"); end
    lateIssues = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.sram_csb !== 1'b1 || busy !== 1'b0) lateIssues++;
      @(negedge clk);
    end
    checks++; if (lateIssues != 0) begin errors++; $display("[TB] FAIL busy_not_queued: got %0d active cycles expected 0", lateIssues); end
  endtask

  task automatic test_reset_mid_command();
    logic seenDone;
    int   idx;
    bus.out_ready = 1'b1;
    applyStimulus(30, 8);
    for (int k = 1; k < 5; k++) @(negedge clk);
    checks++;
    if (bus.out_data !== rowPat(32)) begin
      errors++; $display("[TB] FAIL rst_third_row: got %h expected %h", bus.out_data, rowPat(32));
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy_done: got %b/%b expected 0/0", busy, done); end
    checks++; if (bus.sram_csb !== 1'b1 || bus.sram_wsb !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_csb_wsb: got %b/%b expected 1/1", bus.sram_csb, bus.sram_wsb); end
    checks++; if (bus.sram_raddr !== 6'd0) begin errors++; $display("[TB] FAIL rst_mid_raddr: got %0d expected 0", bus.sram_raddr); end
    checks++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid_last: got %b/%b expected 0/0", bus.out_valid, bus.out_last); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("[TB] FAIL rst_mid_data: got %h expected 0", bus.out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(50, 3);
    idx = 0; seenDone = 1'b0;
    for (int k = 1; k < 30 && !seenDone; k++) begin
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.out_data !== rowPat(50 + idx) || bus.out_last !== logic'(idx == 2)) begin
          errors++; $display("[TB] FAIL rst_new_row idx=%0d: got last %b data %h expected last %b data %h", idx, bus.out_last, bus.out_data, (idx == 2), rowPat(50 + idx));
        end
        idx++;
      end
      if (done === 1'b1) seenDone = 1'b1;
      @(negedge clk);
    end
    checks++; if (idx != 3 || !seenDone) begin errors++; $display("[TB] FAIL rst_new_cmd: got %0d rows done %b expected 3 rows done 1", idx, seenDone); end
  endtask

  initial begin
    for (int r = 0; r < 64; r++) sramMem[r] = rowPat(r);
    bus.out_ready = 1'b0;
    $display("[TB] sram_row_reader bench start");
    test_reset();
    test_stream("basic", 0, 4);
    test_stream("wrap", 62, 4);
    test_zero_count();
    test_stream("full64", 5, 64);
    test_backpressure();
    test_back_to_back_start();
    test_reset_mid_command();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
